// File: rtl/dispense_ctrl.sv
// Vending dispense controller: queues candy/nickel/dime requests in an
// 8-deep FIFO and fires one solenoid at a time, confirming each drop with
// its chute sensor and tracking per-item inventory.
module dispense_ctrl #(
    parameter int PULSE_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int INV_INIT       = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       candy,
    input  logic       n,
    input  logic       d,
    input  logic       candy_sense,
    input  logic       nickel_sense,
    input  logic       dime_sense,
    input  logic       restock,
    input  logic       clear_fault,
    output logic       candy_sol,
    output logic       nickel_sol,
    output logic       dime_sol,
    output logic [7:0] candy_inv,
    output logic [7:0] nickel_inv,
    output logic [7:0] dime_inv,
    output logic       busy,
    output logic       overflow,
    output logic       proto_err,
    output logic       short_err,
    output logic       fault
);

    typedef enum logic [1:0] {
        ITEM_CANDY  = 2'd0,
        ITEM_NICKEL = 2'd1,
        ITEM_DIME   = 2'd2
    } item_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FIRE  = 3'd1,
        S_WAIT  = 3'd2,
        S_GAP   = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    state_t     state;
    item_t      cur_item;
    logic [3:0] pulse_cnt;
    logic [7:0] wait_cnt;
    logic       gap_cnt;

    // The request register is the FIFO's write port; it gives the two-edge
    // latency from a request pulse to the solenoid firing.
    logic       stage_valid;
    item_t      stage_code;

    item_t      mem [8];
    logic [2:0] wr_ptr;
    logic [2:0] rd_ptr;
    logic [3:0] count;

    logic       multi_req;
    logic       pop;
    logic       push_ok;
    item_t      head;
    logic [7:0] head_stock;
    logic       short_hit;
    logic       sense_match;

    assign multi_req = (candy & n) | (candy & d) | (n & d);
    assign pop       = (state == S_IDLE) && (count != 4'd0);
    assign push_ok   = stage_valid && ((count != 4'd8) || pop);
    assign head      = mem[rd_ptr];
    assign short_hit = pop && (head_stock == 8'd0);
    assign busy      = (count != 4'd0) || stage_valid || (state != S_IDLE);

    // Look up remaining stock for the item at the FIFO head and check
    // whether the sensor of the item in flight has fired.
    always_comb begin
        head_stock  = candy_inv;
        sense_match = 1'b0;
        case (head)
            ITEM_NICKEL: head_stock = nickel_inv;
            ITEM_DIME:   head_stock = dime_inv;
            default:     head_stock = candy_inv;
        endcase
        if (state == S_WAIT) begin
            case (cur_item)
                ITEM_NICKEL: sense_match = nickel_sense;
                ITEM_DIME:   sense_match = dime_sense;
                default:     sense_match = candy_sense;
            endcase
        end
    end

    // Capture at most one request per cycle, candy beating dime beating nickel.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_valid <= 1'b0;
            stage_code  <= ITEM_CANDY;
        end else begin
            stage_valid <= candy | n | d;
            stage_code  <= candy ? ITEM_CANDY : (d ? ITEM_DIME : ITEM_NICKEL);
        end
    end

    // FIFO storage; contents need no reset since count guards every read.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= stage_code;
        end
    end

    // FIFO pointers and occupancy; a push on full succeeds only alongside a pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 3'd0;
            rd_ptr <= 3'd0;
            count  <= 4'd0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 3'd1;
            if (pop)     rd_ptr <= rd_ptr + 3'd1;
            count <= count + {3'd0, push_ok} - {3'd0, pop};
        end
    end

    // Dispense sequencer with registered solenoid and fault outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cur_item   <= ITEM_CANDY;
            pulse_cnt  <= 4'd0;
            wait_cnt   <= 8'd0;
            gap_cnt    <= 1'b0;
            candy_sol  <= 1'b0;
            nickel_sol <= 1'b0;
            dime_sol   <= 1'b0;
            fault      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop && (head_stock != 8'd0)) begin
                        state      <= S_FIRE;
                        cur_item   <= head;
                        pulse_cnt  <= 4'd0;
                        candy_sol  <= (head == ITEM_CANDY);
                        nickel_sol <= (head == ITEM_NICKEL);
                        dime_sol   <= (head == ITEM_DIME);
                    end
                end
                S_FIRE: begin
                    if (pulse_cnt == 4'(PULSE_CYCLES - 1)) begin
                        state      <= S_WAIT;
                        wait_cnt   <= 8'd0;
                        candy_sol  <= 1'b0;
                        nickel_sol <= 1'b0;
                        dime_sol   <= 1'b0;
                    end else begin
                        pulse_cnt <= pulse_cnt + 4'd1;
                    end
                end
                S_WAIT: begin
                    if (sense_match) begin
                        state   <= S_GAP;
                        gap_cnt <= 1'b0;
                    end else if (wait_cnt == 8'(TIMEOUT_CYCLES - 1)) begin
                        state <= S_FAULT;
                        fault <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_GAP: begin
                    if (gap_cnt) state <= S_IDLE;
                    else         gap_cnt <= 1'b1;
                end
                S_FAULT: begin
                    if (clear_fault) begin
                        state <= S_IDLE;
                        fault <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Inventory: restock reloads everything and overrides a same-cycle drop.
    always_ff @(posedge clk) begin
        if (rst || restock) begin
            candy_inv  <= 8'(INV_INIT);
            nickel_inv <= 8'(INV_INIT);
            dime_inv   <= 8'(INV_INIT);
        end else if (sense_match) begin
            case (cur_item)
                ITEM_NICKEL: if (nickel_inv != 8'd0) nickel_inv <= nickel_inv - 8'd1;
                ITEM_DIME:   if (dime_inv != 8'd0)   dime_inv   <= dime_inv - 8'd1;
                default:     if (candy_inv != 8'd0)  candy_inv  <= candy_inv - 8'd1;
            endcase
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            proto_err <= 1'b0;
            short_err <= 1'b0;
        end else begin
            if (multi_req)                  proto_err <= 1'b1;
            if (stage_valid && !push_ok)    overflow  <= 1'b1;
            if (short_hit)                  short_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dispense_ctrl.sv
// Directed testbench for dispense_ctrl: a default-parameter instance for
// the main scenarios and an INV_INIT=1 instance for stock exhaustion.
module tb_dispense_ctrl;

    logic       clk;
    logic       rst, candy, n, d, candy_sense, nickel_sense, dime_sense, restock, clear_fault;
    logic       candy_sol, nickel_sol, dime_sol;
    logic [7:0] candy_inv, nickel_inv, dime_inv;
    logic       busy, overflow, proto_err, short_err, fault;
    logic [2:0] sols;

    logic       rst2, n2, nickel_sense2, restock2;
    logic       candy_sol2, nickel_sol2, dime_sol2;
    logic [7:0] candy_inv2, nickel_inv2, dime_inv2;
    logic       busy2, overflow2, proto_err2, short_err2, fault2;

    int checkCount = 0;
    int passCount  = 0;

    assign sols = {candy_sol, nickel_sol, dime_sol};

    dispense_ctrl dut (
        .clk(clk), .rst(rst), .candy(candy), .n(n), .d(d),
        .candy_sense(candy_sense), .nickel_sense(nickel_sense), .dime_sense(dime_sense),
        .restock(restock), .clear_fault(clear_fault),
        .candy_sol(candy_sol), .nickel_sol(nickel_sol), .dime_sol(dime_sol),
        .candy_inv(candy_inv), .nickel_inv(nickel_inv), .dime_inv(dime_inv),
        .busy(busy), .overflow(overflow), .proto_err(proto_err),
        .short_err(short_err), .fault(fault)
    );

    dispense_ctrl #(.INV_INIT(1)) dut2 (
        .clk(clk), .rst(rst2), .candy(1'b0), .n(n2), .d(1'b0),
        .candy_sense(1'b0), .nickel_sense(nickel_sense2), .dime_sense(1'b0),
        .restock(restock2), .clear_fault(1'b0),
        .candy_sol(candy_sol2), .nickel_sol(nickel_sol2), .dime_sol(dime_sol2),
        .candy_inv(candy_inv2), .nickel_inv(nickel_inv2), .dime_inv(dime_inv2),
        .busy(busy2), .overflow(overflow2), .proto_err(proto_err2),
        .short_err(short_err2), .fault(fault2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input int actual, input int expected);
        checkCount++;
        if (actual == expected) passCount++;
        else $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for a solenoid, check which one and its width, optionally answer
    // with the matching drop sensor on the first WAIT cycle.
    task automatic applyStimulus(input string tag, input logic [2:0] expSol, input logic giveSense);
        int waitCnt = 0;
        int highCnt = 0;
        while (sols == 3'b000 && waitCnt < 60) begin
            tick();
            waitCnt++;
        end
        checkOutput({tag, " sol"}, int'(sols), int'(expSol));
        while (sols != 3'b000 && highCnt < 20) begin
            highCnt++;
            tick();
        end
        checkOutput({tag, " width"}, highCnt, 4);
        if (giveSense) begin
            candy_sense  = expSol[2];
            nickel_sense = expSol[1];
            dime_sense   = expSol[0];
            tick();
            candy_sense  = 1'b0;
            nickel_sense = 1'b0;
            dime_sense   = 1'b0;
        end
    endtask

    // Hard stop if something hangs despite the bounded loops.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cnt;
        logic sawDime;
        {rst, candy, n, d, candy_sense, nickel_sense, dime_sense, restock, clear_fault} = '0;
        {rst2, n2, nickel_sense2, restock2} = '0;
        rst = 1'b1;
        rst2 = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        rst2 = 1'b0;

        checkOutput("reset sols", int'(sols), 0);
        checkOutput("reset inv", int'({candy_inv, nickel_inv, dime_inv}), int'({8'd20, 8'd20, 8'd20}));
        checkOutput("reset flags", int'({busy, overflow, proto_err, short_err, fault}), 0);
        checkOutput("reset inv2", int'(nickel_inv2), 1);

        // Single candy: request edge k, solenoid on at k+2 for 4 edges.
        candy = 1'b1;
        tick();
        candy = 1'b0;
        checkOutput("candy k+0 sol", int'(candy_sol), 0);
        tick();
        checkOutput("candy k+1 sol", int'(candy_sol), 0);
        tick();
        checkOutput("candy k+2 sol", int'(candy_sol), 1);
        tick(); tick(); tick();
        checkOutput("candy k+5 sol", int'(candy_sol), 1);
        tick();
        checkOutput("candy k+6 sol", int'(candy_sol), 0);
        tick(); tick();
        candy_sense = 1'b1;
        tick();
        candy_sense = 1'b0;
        checkOutput("candy inv", int'(candy_inv), 19);
        tick();
        checkOutput("candy gap busy", int'(busy), 1);
        tick();
        checkOutput("candy idle busy", int'(busy), 0);

        // Restock then candy, nickel, dime back to back.
        restock = 1'b1;
        tick();
        restock = 1'b0;
        checkOutput("restock candy", int'(candy_inv), 20);
        candy = 1'b1; tick(); candy = 1'b0;
        n = 1'b1;     tick(); n = 1'b0;
        d = 1'b1;     tick(); d = 1'b0;
        applyStimulus("seq candy", 3'b100, 1'b1);
        applyStimulus("seq nickel", 3'b010, 1'b1);
        applyStimulus("seq dime", 3'b001, 1'b1);
        tick(); tick(); tick();
        checkOutput("seq inv", int'({candy_inv, nickel_inv, dime_inv}), int'({8'd19, 8'd19, 8'd19}));
        checkOutput("seq errors", int'({overflow, proto_err, short_err, fault}), 0);
        checkOutput("seq busy", int'(busy), 0);

        // Dime with no drop: fault exactly 64 cycles after WAIT entry.
        d = 1'b1; tick(); d = 1'b0;
        applyStimulus("timeout dime", 3'b001, 1'b0);
        cnt = 0;
        while (!fault && cnt < 100) begin
            tick();
            cnt++;
        end
        checkOutput("timeout cycles", cnt, 64);
        checkOutput("timeout dime inv", int'(dime_inv), 19);
        candy = 1'b1; tick(); candy = 1'b0;
        tick(); tick();
        checkOutput("fault holds sols", int'(sols), 0);
        clear_fault = 1'b1; tick(); clear_fault = 1'b0;
        checkOutput("fault cleared", int'(fault), 0);
        applyStimulus("after fault candy", 3'b100, 1'b1);
        checkOutput("after fault inv", int'(candy_inv), 18);

        // Stall in FAULT, then ten candy requests overflow the 8-deep FIFO.
        d = 1'b1; tick(); d = 1'b0;
        applyStimulus("stall dime", 3'b001, 1'b0);
        cnt = 0;
        while (!fault && cnt < 100) begin
            tick();
            cnt++;
        end
        checkOutput("stall fault", int'(fault), 1);
        candy = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        candy = 1'b0;
        tick();
        checkOutput("overflow flag", int'(overflow), 1);
        clear_fault = 1'b1; tick(); clear_fault = 1'b0;
        for (int i = 0; i < 8; i++) applyStimulus("drain candy", 3'b100, 1'b1);
        cnt = 0;
        while (busy && cnt < 20) begin
            tick();
            cnt++;
        end
        checkOutput("drain inv", int'(candy_inv), 10);
        checkOutput("drain busy", int'(busy), 0);
        checkOutput("drain short", int'(short_err), 0);

        // Stock exhaustion on the INV_INIT=1 instance.
        n2 = 1'b1; tick(); tick(); n2 = 1'b0;
        cnt = 0;
        while (!nickel_sol2 && cnt < 20) begin
            tick();
            cnt++;
        end
        checkOutput("short first sol", int'(nickel_sol2), 1);
        while (nickel_sol2 && cnt < 40) begin
            tick();
            cnt++;
        end
        nickel_sense2 = 1'b1; tick(); nickel_sense2 = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        checkOutput("short inv", int'(nickel_inv2), 0);
        checkOutput("short err", int'(short_err2), 1);
        checkOutput("short busy", int'(busy2), 0);
        restock2 = 1'b1; tick(); restock2 = 1'b0;
        checkOutput("short restock", int'(nickel_inv2), 1);

        // Candy and dime together: only candy served, proto_err sticks.
        candy = 1'b1; d = 1'b1; tick(); candy = 1'b0; d = 1'b0;
        tick();
        checkOutput("proto flag", int'(proto_err), 1);
        applyStimulus("proto candy", 3'b100, 1'b1);
        sawDime = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (dime_sol) sawDime = 1'b1;
        end
        checkOutput("proto no dime", int'(sawDime), 0);
        checkOutput("proto inv", int'(candy_inv), 9);

        // Reset asserted in the middle of a candy pulse.
        candy = 1'b1; tick(); candy = 1'b0;
        cnt = 0;
        while (!candy_sol && cnt < 20) begin
            tick();
            cnt++;
        end
        tick();
        checkOutput("midfire sol", int'(candy_sol), 1);
        rst = 1'b1; tick(); rst = 1'b0;
        checkOutput("rst sols", int'(sols), 0);
        checkOutput("rst flags", int'({busy, overflow, proto_err, short_err, fault}), 0);
        checkOutput("rst inv", int'(candy_inv), 20);
        tick(); tick(); tick();
        checkOutput("rst stays idle", int'({sols, busy}), 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/dispense_ctrl.md
DISPENSE_CTRL -- requirements
Module: dispense_ctrl

Interface
REQ-001 Parameter PULSE_CYCLES, default 4: solenoid on-time in clocks (range 1-15).
REQ-002 Parameter TIMEOUT_CYCLES, default 64: max clocks from solenoid release to drop sensor (range 1-255).
REQ-003 Parameter INV_INIT, default 20: per-item stock loaded at reset/restock (range 0-255).
REQ-004 Ports SHALL be, in order:
 - clk  in  1  single clock, all logic on rising edge.
 - rst  in  1  synchronous, active-high reset.
 - candy  in  1  one-clock pulse, one candy owed.
 - n  in  1  one-clock pulse, one nickel of change owed.
 - d  in  1  one-clock pulse, one dime of change owed.
 - candy_sense / nickel_sense / dime_sense  in  1 each  drop sensor, high while the item passes the chute.
 - restock  in  1  one-clock pulse, reload all inventories to INV_INIT.
 - clear_fault  in  1  one-clock pulse, leave FAULT.
 - candy_sol / nickel_sol / dime_sol  out  1 each  registered actuator drive.
 - candy_inv / nickel_inv / dime_inv  out  8 each  remaining stock.
 - busy  out  1  FIFO non-empty or FSM not IDLE.
 - overflow  out  1  sticky, request lost on full FIFO.
 - proto_err  out  1  sticky, more than one of candy/n/d high in one cycle.
 - short_err  out  1  sticky, request dropped because stock was 0.
 - fault  out  1  high in FAULT state.

Function
REQ-005 Requests SHALL be queued in an 8-entry FIFO of 2-bit codes (candy, nickel, dime), one write per cycle, FIFO order preserved.
REQ-006 If several of candy/n/d are high in one cycle, only one SHALL be queued, priority candy > d > n, and proto_err SHALL set.
REQ-007 A request arriving with FIFO full SHALL be discarded and overflow set; simultaneous pop and push on full SHALL succeed with no overflow.
REQ-008 FSM states SHALL be IDLE, FIRE, WAIT, GAP, FAULT.
REQ-009 IDLE: FIFO non-empty -> pop head; if head stock > 0 go FIRE, else set short_err, stay IDLE (next entry considered the following cycle).
REQ-010 A request sampled at edge k SHALL, with FSM in IDLE and FIFO empty, reach FIRE at edge k+2, with the selected *_sol high for exactly PULSE_CYCLES cycles from that edge.
REQ-011 FIRE -> WAIT after PULSE_CYCLES cycles; only the solenoid matching the popped item SHALL be driven, never two at once.
REQ-012 WAIT: matching sense high -> decrement that item's inventory by 1 (saturating at 0) and go GAP; sense not seen within TIMEOUT_CYCLES cycles -> FAULT, inventory unchanged.
REQ-013 Sense pulses of non-matching items, or any sense outside WAIT, SHALL be ignored.
REQ-014 GAP SHALL last 2 cycles, then IDLE.
REQ-015 FAULT: all solenoids low, fault=1, FIFO still accepts requests; clear_fault -> IDLE next edge (failed item is not retried).
REQ-016 restock SHALL load all three inventories to INV_INIT at the next edge, in any state; restock same cycle as a decrement: restock wins.
REQ-017 Sticky errors SHALL clear only on rst.
REQ-018 busy SHALL be combinational OR of FIFO non-empty and state != IDLE.

Reset
REQ-019 rst high at an edge SHALL set: state IDLE, FIFO empty, all *_sol 0, inventories INV_INIT, overflow/proto_err/short_err/fault 0, counters 0; rst has priority over every other input including mid-pulse and mid-FAULT.

Verification
REQ-020 Single candy pulse at edge 10, candy_sense high 3 cycles after solenoid release -> candy_sol high edges 12-15, candy_inv 20->19, busy low after GAP.
REQ-021 Sequence candy, n, d on consecutive cycles -> solenoids fire in that order, one at a time, inventories each 19, no errors.
REQ-022 No sense after dime fire -> fault=1 exactly TIMEOUT_CYCLES=64 cycles after WAIT entry, dime_inv unchanged; clear_fault -> next queued request served.
REQ-023 Ten back-to-back candy pulses while FSM stalled in FAULT -> 8 queued, overflow=1; after clear_fault all 8 dispensed.
REQ-024 INV_INIT=1: two nickel requests -> first dispensed, nickel_inv=0, second dropped with short_err=1; restock -> nickel_inv=1.
REQ-025 candy and d high together -> candy queued only, proto_err=1; rst asserted mid-FIRE -> candy_sol low on next edge, all outputs at reset values.
